mxu_core_wrapper: RTL and testbench
===================================

# mxu_core_wrapper

Weight-stationary M×K integer matrix-multiply unit (MXU) for the DTPU datapath. It computes one output vector y = aᵀ·W per input vector a, using a skewed systolic array of multiply-accumulate cells. Every operand and result lane is a 64-bit slot, and the active integer precision is selected at run time. The block sits between the DTPU input/weight buffers and the output FIFO.

## Interface
Parameters:
- M, 4: number of input lanes (array rows).
- K, 4: number of output lanes (array columns); M = K is the supported configuration.
- max_data_width, 64: width of each lane slot.
- MAX_BOARD_DSP, 220: synthesis budget. Cells with index r*K+c < MAX_BOARD_DSP carry use_dsp="yes"; the rest use fabric. No functional effect.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears every register.
- enable  in  1  global clock enable for all pipeline registers.
- data_type  in  LOG_ALLOWED_PRECISIONS  precision: INT8, INT16, INT32, INT64.
- enable_in_ff  in  1  clock enable of the input register stage.
- enable_out_ff  in  1  clock enable of the output register.
- enable_chain  in  1  1 = accumulate into y; 0 = overwrite y.
- enable_fp_unit  in  2  reserved; ignored.
- test_mode  in  1  1 = bypass the array.
- input_data  in  M*max_data_width  lane r = bits [r*64 +: 64].
- weight  in  M*K*max_data_width  W[r][c] = bits [(r*K+c)*64 +: 64].
- y  out  K*max_data_width  lane c = bits [c*64 +: 64].

## Operation
- Operand decode: each lane's low w bits (w = 8/16/32/64 per data_type) are sign-extended to 64 bits. Upper bits are ignored.
- Result: y[c] = Σ_r a[r]·W[r][c] in 64-bit two's complement, modulo 2^64. No saturation.
- Input stage: captures input_data and weight when enable & enable_in_ff.
- Skew: row r's activation passes through r skew registers. Weights are stationary, taken directly from the input stage.
- Cell (r,c): registers p[r][c] = p[r-1][c] + a[r]·W[r][c], with p[-1] = 0.
- Output stage: when enable & enable_out_ff, y ← p[M-1] (enable_chain=0) or y ← y + p[M-1] (enable_chain=1).
- test_mode=1: the output register loads the input-stage lane c (for c<M) instead of p[M-1]; enable_chain is ignored.
- enable=0: every register holds; y holds.
- A change in data_type or weight takes effect on the next capture. In-flight results mix old and new operands until the pipeline drains; the caller drains.

## Timing
- Reset: y = 0, all cell, skew and input registers = 0. A reset mid-operation discards all in-flight data.
- Latency with enables held high: capture at edge t, y valid after edge t+M+1. That is 1 input + M array/skew + 1 output stage (M=3: 4 edges after capture; M=16: 17).
- Throughput: one vector per cycle while enable=1.
- test_mode latency: 2 edges.

## Structure
- Shared package/header precision_def: INT8=0, INT16=1, INT32=2, INT64=3, LOG_ALLOWED_PRECISIONS=2, and a sign-extend function.
- One sub-module, mxu_mac_cell: registered 64×64 signed multiply plus 64-bit add, with enable and async reset.
- Generate loops build the array, skew chains and output stage.

## Test plan
- Reset: assert reset low mid-stream → y = 0 immediately; the prior result is not reproduced after release.
- INT8 3×3: input 0xfe per lane, W all 0xff, enables=1 → each y lane = 64'h6 after M+2 edges.
- INT8 4×4: input 0xca, W all 0xff → each lane = 64'hd8 (216).
- INT8 16×16: inputs lanes 0-7 = 0x01, lanes 8-15 = 0x03; W rows of 0xff/0x11…0x88 → lanes match the golden model Σ a·W (signed). Upper-bit garbage in the slots is ignored.
- enable_chain=1 with constant 3×3 stimulus → y increments by 6 each cycle. enable=0 → y frozen.
- test_mode=1, data_type=INT64, input lanes 1,2,3 → y lanes 1,2,3 after 2 edges. INT64 overflow wraps modulo 2^64.

Source files
------------

// File: rtl/mxu_core_wrapper_pkg.sv
// Precision encoding and operand decode shared by the MXU datapath.
package precision_def;

  localparam int LOG_ALLOWED_PRECISIONS = 2;

  typedef enum logic [LOG_ALLOWED_PRECISIONS-1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } precision_e;

  // Only the low w bits of a slot carry the operand; the rest is don't-care.
  function automatic logic [63:0] sign_extend(input logic [63:0] v,
                                              input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
    logic [63:0] r;
    r = v;
    case (precision_e'(dt))
      INT8:    r = {{56{v[7]}}, v[7:0]};
      INT16:   r = {{48{v[15]}}, v[15:0]};
      INT32:   r = {{32{v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mxu_mac_cell.sv
// One systolic MAC cell: registers p_out = p_in + a*w, modulo 2^W.
module mxu_mac_cell #(
  parameter int W       = 64,
  parameter bit USE_DSP = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] w,
  input  logic [W-1:0] p_in,
  output logic [W-1:0] p_out
);

  logic [W-1:0] mult;

  // Only the low W bits are kept, which are identical for signed and unsigned.
  if (USE_DSP) begin : g_dsp
    (* use_dsp = "yes" *) logic [W-1:0] prod;
    assign prod = a * w;
    assign mult = prod;
  end else begin : g_fabric
    (* use_dsp = "no" *) logic [W-1:0] prod;
    assign prod = a * w;
    assign mult = prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_out <= '0;
    end else if (en) begin
      p_out <= p_in + mult;
    end
  end

endmodule

// File: rtl/mxu_core_wrapper.sv
// Weight-stationary M x K integer MXU: y = a^T * W through a skewed systolic array.
module mxu_core_wrapper
  import precision_def::*;
#(
  parameter int M              = 4,
  parameter int K              = 4,
  parameter int max_data_width = 64,
  parameter int MAX_BOARD_DSP  = 220
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [LOG_ALLOWED_PRECISIONS-1:0]   data_type,
  input  logic                                enable_in_ff,
  input  logic                                enable_out_ff,
  input  logic                                enable_chain,
  input  logic [1:0]                          enable_fp_unit,
  input  logic                                test_mode,
  input  logic [M*max_data_width-1:0]         input_data,
  input  logic [M*K*max_data_width-1:0]       weight,
  output logic [K*max_data_width-1:0]         y
);

  localparam int DW = max_data_width;

  logic [DW-1:0] a_in  [M];
  logic [DW-1:0] w_in  [M][K];
  logic [DW-1:0] a_arr [M];
  logic [DW-1:0] p     [M][K];

  logic unused_fp;
  assign unused_fp = ^enable_fp_unit;

  // Operands are decoded at capture so a precision change only affects new vectors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < M; r++) begin
        a_in[r] <= '0;
        for (int c = 0; c < K; c++) w_in[r][c] <= '0;
      end
    end else if (enable && enable_in_ff) begin
      for (int r = 0; r < M; r++) begin
        a_in[r] <= sign_extend(input_data[r*DW +: DW], data_type);
        for (int c = 0; c < K; c++)
          w_in[r][c] <= sign_extend(weight[(r*K+c)*DW +: DW], data_type);
      end
    end
  end

  for (genvar r = 0; r < M; r++) begin : g_row
    if (r == 0) begin : g_noskew
      assign a_arr[r] = a_in[r];
    end else begin : g_skew
      logic [DW-1:0] sk [r];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
        end else if (enable) begin
          sk[0] <= a_in[r];
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      end
      assign a_arr[r] = sk[r-1];
    end

    for (genvar c = 0; c < K; c++) begin : g_col
      logic [DW-1:0] p_prev;
      if (r == 0) begin : g_top
        assign p_prev = '0;
      end else begin : g_chain
        assign p_prev = p[r-1][c];
      end

      mxu_mac_cell #(
        .W       (DW),
        .USE_DSP ((r*K + c) < MAX_BOARD_DSP)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .a     (a_arr[r]),
        .w     (w_in[r][c]),
        .p_in  (p_prev),
        .p_out (p[r][c])
      );
    end
  end

  for (genvar c = 0; c < K; c++) begin : g_out
    logic [DW-1:0] bypass;
    logic [DW-1:0] y_q;
    if (c < M) begin : g_byp
      assign bypass = a_in[c];
    end else begin : g_nobyp
      assign bypass = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        y_q <= '0;
      end else if (enable && enable_out_ff) begin
        if (test_mode)         y_q <= bypass;
        else if (enable_chain) y_q <= y_q + p[M-1][c];
        else                   y_q <= p[M-1][c];
      end
    end

    assign y[c*DW +: DW] = y_q;
  end

endmodule

// File: tb/tb_mxu_core_wrapper.sv
// Directed scoreboard bench for mxu_core_wrapper (M = K = 4).
module tb_mxu_core_wrapper;

  localparam int M  = 4;
  localparam int K  = 4;
  localparam int DW = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [1:0]            data_type;
  logic                  enable_in_ff;
  logic                  enable_out_ff;
  logic                  enable_chain;
  logic [1:0]            enable_fp_unit;
  logic                  test_mode;
  logic [M*DW-1:0]       input_data;
  logic [M*K*DW-1:0]     weight;
  logic [K*DW-1:0]       y;

  mxu_core_wrapper #(.M(M), .K(K), .max_data_width(DW), .MAX_BOARD_DSP(220)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .data_type      (data_type),
    .enable_in_ff   (enable_in_ff),
    .enable_out_ff  (enable_out_ff),
    .enable_chain   (enable_chain),
    .enable_fp_unit (enable_fp_unit),
    .test_mode      (test_mode),
    .input_data     (input_data),
    .weight         (weight),
    .y              (y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [K*DW-1:0] exp;
    string           tag;
  } sb_t;

  sb_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  function automatic logic signed [63:0] sx(input logic [63:0] v, input int sh);
    logic signed [63:0] t;
    t = $signed(v << sh);
    return t >>> sh;
  endfunction

  function automatic logic [K*DW-1:0] model(input logic [M*DW-1:0] a,
                                            input logic [M*K*DW-1:0] w,
                                            input logic [1:0] dt);
    logic [K*DW-1:0] res;
    logic [63:0]     acc;
    int              sh;
    sh  = 64 - (8 << dt);
    res = '0;
    for (int c = 0; c < K; c++) begin
      acc = '0;
      for (int r = 0; r < M; r++)
        acc = acc + sx(a[r*DW +: DW], sh) * sx(w[(r*K+c)*DW +: DW], sh);
      res[c*DW +: DW] = acc;
    end
    return res;
  endfunction

  function automatic logic [M*DW-1:0] lanes(input logic [63:0] v);
    logic [M*DW-1:0] r;
    for (int i = 0; i < M; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [M*K*DW-1:0] wall(input logic [63:0] v);
    logic [M*K*DW-1:0] r;
    for (int i = 0; i < M*K; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [M*DW-1:0] rnd_a();
    logic [M*DW-1:0] r;
    for (int i = 0; i < M; i++) r[i*DW +: DW] = {$urandom(), $urandom()};
    return r;
  endfunction

  function automatic logic [M*K*DW-1:0] rnd_w();
    logic [M*K*DW-1:0] r;
    for (int i = 0; i < M*K; i++) r[i*DW +: DW] = {$urandom(), $urandom()};
    return r;
  endfunction

  task automatic check(input string tag, input logic [K*DW-1:0] exp);
    n_assert++;
    assert (y === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, y, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check(e.tag, e.exp);
    end
  endtask

  task automatic push(input string tag, input logic [K*DW-1:0] exp, input int lat);
    sb.push_back('{cyc + lat, exp, tag});
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL drain: outstanding=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M*DW-1:0] a_v;

    reset          = 1'b0;
    enable         = 1'b1;
    enable_in_ff   = 1'b1;
    enable_out_ff  = 1'b1;
    enable_chain   = 1'b0;
    enable_fp_unit = 2'b11;
    test_mode      = 1'b0;
    data_type      = 2'd0;
    input_data     = '0;
    weight         = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0);
    reset = 1'b1;

    // INT8 directed: -2 * -1 over 4 rows, and -54 * -1 over 4 rows
    weight     = wall(64'hff);
    input_data = lanes(64'hfe);
    push("int8_fe", lanes(64'd8), M + 2);
    tick();
    drain();

    input_data = lanes(64'hca);
    push("int8_ca", lanes(64'd216), M + 2);
    tick();
    drain();

    // Lanes 0-1 = 0x01, lanes 2-3 = 0x03, with garbage above the active byte
    a_v = {64'hdead_beef_1234_5603, 64'h0000_0000_0000_0103,
           64'hffff_ffff_ffff_ff01, 64'h5555_aaaa_0000_0001};
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++)
        weight[(r*K+c)*DW +: DW] = {56'hc0ffee_0000_0000, (r == 0) ? 8'hff : 8'(8'h11 * (c + 1 + r))};
    input_data = a_v;
    push("int8_garbage", model(a_v, weight, 2'd0), M + 2);
    tick();
    drain();

    // Random back-to-back streams at every precision
    for (int dt = 0; dt < 4; dt++) begin
      data_type = 2'(dt);
      weight    = rnd_w();
      for (int v = 0; v < 5; v++) begin
        input_data = rnd_a();
        push($sformatf("rand_dt%0d_v%0d", dt, v), model(input_data, weight, 2'(dt)), M + 2);
        tick();
      end
      drain();
    end

    // INT64 wraparound: 4 * (0x7fff..ff * 2) = -8
    data_type  = 2'd3;
    weight     = wall(64'd2);
    input_data = lanes(64'h7fff_ffff_ffff_ffff);
    push("int64_wrap", lanes(64'hffff_ffff_ffff_fff8), M + 2);
    tick();
    drain();

    // Accumulate, then freeze
    data_type  = 2'd0;
    weight     = wall(64'hff);
    input_data = lanes(64'hfe);
    push("chain_base", lanes(64'd8), M + 2);
    tick();
    drain();
    enable_chain = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      push($sformatf("chain_acc%0d", k), lanes(64'(8 * k)), 1);
      tick();
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push($sformatf("freeze%0d", k), lanes(64'd32), 1);
      tick();
    end
    enable       = 1'b1;
    enable_chain = 1'b0;
    push("chain_off", lanes(64'd8), 1);
    tick();

    // Bypass: two-edge path, chain ignored
    data_type    = 2'd3;
    test_mode    = 1'b1;
    enable_chain = 1'b1;
    input_data   = {64'd3, 64'd2, 64'd1, 64'h8000_0000_0000_0005};
    push("test_mode", {64'd3, 64'd2, 64'd1, 64'h8000_0000_0000_0005}, 2);
    tick();
    drain();
    test_mode    = 1'b0;
    enable_chain = 1'b0;

    // Asynchronous reset mid-stream discards in-flight work
    data_type  = 2'd0;
    weight     = wall(64'hff);
    input_data = lanes(64'hfe);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_async", '0);
    input_data = '0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < M + 3; i++) begin
      push($sformatf("post_reset%0d", i), '0, 1);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
